// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the
// load-use hazard flag (ID), the taken-branch indication (EX) and the
// data-memory request/ready handshake (MEM) into a single consistent set of
// per-stage enable and bubble controls. A memory-wait FSM bounds how long a
// multi-cycle access may stall the pipeline; when that bound is exceeded, the
// FSM freezes the pipeline and raises a sticky error. Two saturating
// performance counters track stall cycles and branch flushes.
//
// Parameters:
//   MEM_TIMEOUT  max consecutive wait cycles tolerated in MEM_WAIT (>= 2)
//   CNT_W        width of the performance counters
//
// Ports:
//   clk                in   pipeline clock, rising edge
//   reset              in   synchronous, active-high reset
//   load_use_hazard_i  in   load-use stall request (ID)
//   branch_taken_i     in   branch/jump resolved taken (EX)
//   mem_req_i          in   EX/MEM holds a lw/sw this cycle
//   mem_ready_i        in   data memory completes the access this cycle
//   pc_enable_o        out  PC load enable
//   ifid_enable_o      out  IF/ID load enable
//   ifid_flush_o       out  IF/ID loads a NOP
//   idex_enable_o      out  ID/EX load enable
//   idex_bubble_o      out  ID/EX loads zeroed control
//   exmem_enable_o     out  EX/MEM load enable
//   memwb_bubble_o     out  MEM/WB loads zeroed control
//   error_o            out  sticky memory-timeout error
//   stall_count_o      out  cycles with pc_enable_o = 0 (saturating)
//   flush_count_o      out  branch flushes issued (saturating)
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use_hazard_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_enable_o,
    output logic             ifid_enable_o,
    output logic             ifid_flush_o,
    output logic             idex_enable_o,
    output logic             idex_bubble_o,
    output logic             exmem_enable_o,
    output logic             memwb_bubble_o,
    output logic             error_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        C_NORMAL,
        C_FREEZE,
        C_FLUSH,
        C_LOAD_STALL,
        C_RESET
    } ctrl_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              error_next;
    logic              mem_stall;
    ctrl_t             run_sel;
    ctrl_t             ctrl_sel;

    // An outstanding access the memory has not completed yet.
    assign mem_stall = mem_req_i & ~mem_ready_i;

    // Lower-priority RUN rules. A taken branch voids the hazard of the
    // instruction it flushes, so it wins over the load-use stall.
    always_comb begin
        run_sel = C_NORMAL;
        if (branch_taken_i) begin
            run_sel = C_FLUSH;
        end else if (load_use_hazard_i) begin
            run_sel = C_LOAD_STALL;
        end
    end

    // -----------------------------------------------------------------------
    // State register, wait counter and sticky error
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            error_o  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            error_o  <= error_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        error_next    = error_o;
        unique case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                // Ready is checked first so a completion on the timeout
                // cycle still releases the pipeline without an error.
                if (mem_ready_i) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                    state_next = ST_ERROR;
                    error_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                end
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic (Mealy): pick a control set, then decode it
    // -----------------------------------------------------------------------
    always_comb begin
        ctrl_sel = C_FREEZE;
        if (reset) begin
            ctrl_sel = C_RESET;
        end else begin
            unique case (state)
                ST_RUN:      ctrl_sel = mem_stall   ? C_FREEZE : run_sel;
                ST_MEM_WAIT: ctrl_sel = mem_ready_i ? run_sel  : C_FREEZE;
                ST_ERROR:    ctrl_sel = C_FREEZE;
                default:     ctrl_sel = C_FREEZE;
            endcase
        end

        pc_enable_o    = 1'b1;
        ifid_enable_o  = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_enable_o  = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_enable_o = 1'b1;
        memwb_bubble_o = 1'b0;
        unique case (ctrl_sel)
            C_NORMAL: begin
            end
            C_FREEZE: begin
                // Hold everything up to EX/MEM; MEM/WB gets a bubble so the
                // stalled access does not retire more than once.
                pc_enable_o    = 1'b0;
                ifid_enable_o  = 1'b0;
                idex_enable_o  = 1'b0;
                exmem_enable_o = 1'b0;
                memwb_bubble_o = 1'b1;
            end
            C_FLUSH: begin
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
            end
            C_LOAD_STALL: begin
                pc_enable_o   = 1'b0;
                ifid_enable_o = 1'b0;
                idex_bubble_o = 1'b1;
            end
            C_RESET: begin
                // Hold the PC and clock NOPs/bubbles into every stage.
                pc_enable_o    = 1'b0;
                ifid_flush_o   = 1'b1;
                idex_bubble_o  = 1'b1;
                memwb_bubble_o = 1'b1;
            end
            default: begin
                pc_enable_o    = 1'b0;
                ifid_enable_o  = 1'b0;
                idex_enable_o  = 1'b0;
                exmem_enable_o = 1'b0;
                memwb_bubble_o = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Saturating performance counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_o <= '0;
            flush_count_o <= '0;
        end else begin
            if (!pc_enable_o && stall_count_o != CNT_MAX) begin
                stall_count_o <= stall_count_o + CNT_W'(1);
            end
            if (ifid_flush_o && flush_count_o != CNT_MAX) begin
                flush_count_o <= flush_count_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Directed bench for pipeline_stall_controller. Two instances share the
// stimulus: the default-parameter DUT and a CNT_W=4 copy used to observe
// counter saturation. Inputs change 1 time unit after the rising edge; the
// Mealy controls and registered outputs are sampled on the falling edge.
// Controls are compared packed as
// {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble}.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    localparam logic [6:0] NORMAL     = 7'b1101010;
    localparam logic [6:0] FREEZE     = 7'b0000001;
    localparam logic [6:0] FLUSH      = 7'b1111110;
    localparam logic [6:0] LOAD_STALL = 7'b0001110;
    localparam logic [6:0] RESET_SET  = 7'b0111111;

    logic clk = 1'b0;
    logic reset;
    logic load_use_hazard, branch_taken, mem_req, mem_ready;

    logic        pc_en, ifid_en, ifid_fl, idex_en, idex_bub, exmem_en, memwb_bub, err;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_fl, s_idex_en, s_idex_bub, s_exmem_en, s_memwb_bub, s_err;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    logic [6:0]  ctrl, s_ctrl;
    assign ctrl   = {pc_en, ifid_en, ifid_fl, idex_en, idex_bub, exmem_en, memwb_bub};
    assign s_ctrl = {s_pc_en, s_ifid_en, s_ifid_fl, s_idex_en, s_idex_bub, s_exmem_en, s_memwb_bub};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .load_use_hazard_i (load_use_hazard),
        .branch_taken_i    (branch_taken),
        .mem_req_i         (mem_req),
        .mem_ready_i       (mem_ready),
        .pc_enable_o       (pc_en),
        .ifid_enable_o     (ifid_en),
        .ifid_flush_o      (ifid_fl),
        .idex_enable_o     (idex_en),
        .idex_bubble_o     (idex_bub),
        .exmem_enable_o    (exmem_en),
        .memwb_bubble_o    (memwb_bub),
        .error_o           (err),
        .stall_count_o     (stall_cnt),
        .flush_count_o     (flush_cnt)
    );

    pipeline_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(4)) dut_sat (
        .clk               (clk),
        .reset             (reset),
        .load_use_hazard_i (load_use_hazard),
        .branch_taken_i    (branch_taken),
        .mem_req_i         (mem_req),
        .mem_ready_i       (mem_ready),
        .pc_enable_o       (s_pc_en),
        .ifid_enable_o     (s_ifid_en),
        .ifid_flush_o      (s_ifid_fl),
        .idex_enable_o     (s_idex_en),
        .idex_bubble_o     (s_idex_bub),
        .exmem_enable_o    (s_exmem_en),
        .memwb_bubble_o    (s_memwb_bub),
        .error_o           (s_err),
        .stall_count_o     (s_stall_cnt),
        .flush_count_o     (s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs and wait to the falling edge for sampling.
    task automatic drive(input logic lu, input logic br, input logic req, input logic rdy);
        load_use_hazard = lu;
        branch_taken    = br;
        mem_req         = req;
        mem_ready       = rdy;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        load_use_hazard = 1'b0;
        branch_taken    = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;

        // Reset for two cycles.
        @(negedge clk);
        chk("reset_ctrl", 32'(ctrl), 32'(RESET_SET));
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset.
        drive(0, 0, 0, 0);
        chk("idle_ctrl", 32'(ctrl), 32'(NORMAL));
        chk("idle_stall", 32'(stall_cnt), 32'd0);
        chk("idle_flush", 32'(flush_cnt), 32'd0);
        chk("idle_err", 32'(err), 32'd0);
        tick();

        // Single load-use stall.
        drive(1, 0, 0, 0);
        chk("load_stall_ctrl", 32'(ctrl), 32'(LOAD_STALL));
        tick();
        drive(0, 0, 0, 0);
        chk("after_load_ctrl", 32'(ctrl), 32'(NORMAL));
        chk("after_load_stall", 32'(stall_cnt), 32'd1);
        tick();

        // Branch beats load-use hazard.
        drive(1, 1, 0, 0);
        chk("branch_ctrl", 32'(ctrl), 32'(FLUSH));
        tick();
        drive(0, 0, 0, 0);
        chk("branch_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("branch_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();

        // Three wait cycles, then release.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            chk($sformatf("wait3_freeze_%0d", i), 32'(ctrl), 32'(FREEZE));
            tick();
        end
        drive(0, 0, 1, 1);
        chk("wait3_release", 32'(ctrl), 32'(NORMAL));
        tick();
        drive(0, 0, 0, 0);
        chk("wait3_run", 32'(ctrl), 32'(NORMAL));
        chk("wait3_stall_cnt", 32'(stall_cnt), 32'd4);
        tick();

        // Release cycle with branch and hazard follows RUN priority.
        drive(0, 0, 1, 0);
        chk("wait1_freeze", 32'(ctrl), 32'(FREEZE));
        tick();
        drive(1, 1, 1, 1);
        chk("release_branch", 32'(ctrl), 32'(FLUSH));
        tick();
        drive(0, 0, 0, 0);
        chk("release_branch_stall", 32'(stall_cnt), 32'd5);
        chk("release_branch_flush", 32'(flush_cnt), 32'd2);
        tick();

        // Ready arrives exactly on the timeout cycle: release, no error.
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 0);
            if (i == 15) chk("edge_freeze_last", 32'(ctrl), 32'(FREEZE));
            tick();
        end
        drive(0, 0, 1, 1);
        chk("edge_release", 32'(ctrl), 32'(NORMAL));
        chk("edge_err_pre", 32'(err), 32'd0);
        tick();
        drive(0, 0, 0, 0);
        chk("edge_err_post", 32'(err), 32'd0);
        chk("edge_stall_cnt", 32'(stall_cnt), 32'd21);
        tick();

        // Ready never arrives: error after 17 frozen cycles.
        for (int i = 0; i < 17; i++) begin
            drive(0, 0, 1, 0);
            chk($sformatf("tmo_freeze_%0d", i), 32'(ctrl), 32'(FREEZE));
            if (i == 16) chk("tmo_err_pre", 32'(err), 32'd0);
            tick();
        end
        drive(0, 0, 0, 1);
        chk("err_ctrl_ready", 32'(ctrl), 32'(FREEZE));
        chk("err_set", 32'(err), 32'd1);
        chk("err_stall_cnt", 32'(stall_cnt), 32'd38);
        tick();
        drive(1, 1, 0, 0);
        chk("err_ctrl_branch", 32'(ctrl), 32'(FREEZE));
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_stall_cnt2", 32'(stall_cnt), 32'd39);
        chk("err_flush_cnt", 32'(flush_cnt), 32'd2);
        tick();

        // One-cycle reset leaves ERROR.
        reset = 1'b1;
        drive(0, 0, 0, 0);
        chk("err_reset_ctrl", 32'(ctrl), 32'(RESET_SET));
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        chk("post_err_ctrl", 32'(ctrl), 32'(NORMAL));
        chk("post_err_err", 32'(err), 32'd0);
        chk("post_err_stall", 32'(stall_cnt), 32'd0);
        chk("post_err_flush", 32'(flush_cnt), 32'd0);
        tick();

        // Reset in the middle of MEM_WAIT.
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0);
            tick();
        end
        reset = 1'b1;
        drive(0, 0, 1, 0);
        chk("midwait_reset_ctrl", 32'(ctrl), 32'(RESET_SET));
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        chk("midwait_run_ctrl", 32'(ctrl), 32'(NORMAL));
        chk("midwait_stall", 32'(stall_cnt), 32'd0);
        tick();

        // 20 consecutive load-use stalls: the 4-bit counter saturates.
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0);
            if (i == 15) chk("sat_at_15", 32'(s_stall_cnt), 32'd15);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("sat_stall_cnt", 32'(s_stall_cnt), 32'd15);
        chk("wide_stall_cnt", 32'(stall_cnt), 32'd20);
        chk("sat_ctrl", 32'(s_ctrl), 32'(NORMAL));
        chk("sat_err", 32'(s_err), 32'd0);
        chk("sat_flush_cnt", 32'(s_flush_cnt), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
